// File: rtl/cam_crop_fifo.sv
// Crops a fixed window out of the camera pixel stream and buffers kept pixels in a
// first-word-fall-through FIFO. Define CAM_CROP_DECIM_EN for 2x2 decimation inside the window.
module cam_crop_fifo #(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned CROP_X0 = 0,
  parameter int unsigned CROP_Y0 = 0,
  parameter int unsigned CROP_W  = 320,
  parameter int unsigned CROP_H  = 240,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               pixel_valid_i,
  input  logic [15:0]        pixel_i,
  input  logic               vstart_i,
  input  logic               hstart_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [15:0]        out_data_o,
  output logic               out_sof_o,
  output logic               out_eol_o,
  output logic [FIFO_AW:0]   fifo_level_o,
  output logic               overflow_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned EW    = 18;
`ifdef CAM_CROP_DECIM_EN
  localparam int unsigned EOL_OFF = CROP_W - 2;
`else
  localparam int unsigned EOL_OFF = CROP_W - 1;
`endif

  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               locked_q, locked_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      head;

  logic        take, in_win, keep, sof, eol;
  logic        empty, full, push, pop;
  logic [31:0] x_off, y_off;

  // Position of the current pixel; the first vstart pixel also acquires lock.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    locked_d = locked_q;
    take     = pixel_valid_i && (locked_q || vstart_i);
    if (take) begin
      locked_d = 1'b1;
      if (vstart_i) begin
        x_d = '0;
        y_d = '0;
      end else if (hstart_i) begin
        x_d = '0;
        y_d = (&y_q) ? y_q : y_q + YW'(1);
      end else begin
        x_d = (&x_q) ? x_q : x_q + XW'(1);
      end
    end
  end

  // Offsets wrap to huge values left/above the window, so one compare bounds each axis.
  always_comb begin
    x_off  = 32'(x_d) - 32'(CROP_X0);
    y_off  = 32'(y_d) - 32'(CROP_Y0);
    in_win = (x_off < 32'(CROP_W)) && (y_off < 32'(CROP_H));
`ifdef CAM_CROP_DECIM_EN
    in_win = in_win && !x_off[0] && !y_off[0];
`endif
    keep   = take && in_win;
    sof    = (x_off == 32'd0) && (y_off == 32'd0);
    eol    = (x_off == 32'(EOL_OFF));
  end

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    pop      = !empty && out_ready_i;
    push     = keep && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
    ovf_d    = ovf_q || (keep && full && !pop);
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      locked_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      locked_q <= locked_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sof, eol, pixel_i};
    end
  end

  // Head fields are forced to zero while empty so the reset state reads all-zero.
  assign head         = mem_q[rd_ptr_q];
  assign out_valid_o  = !empty;
  assign out_data_o   = empty ? 16'h0 : head[15:0];
  assign out_eol_o    = !empty && head[16];
  assign out_sof_o    = !empty && head[17];
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cam_crop_fifo.sv
// Bench for cam_crop_fifo: two instances (2x2 window at (1,1); 4x4 window at (2,3) with
// 4-bit counters) checked every cycle against a queue-based reference model.
module tb_cam_crop_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s, pv_s, vs_s, hs_s, rdy_s;
  logic [15:0] pix_s;
  logic        a_valid, a_sof, a_eol, a_ovf, b_valid, b_sof, b_eol, b_ovf;
  logic [15:0] a_data, b_data;
  logic [4:0]  a_level, b_level;

  int checks = 0;
  int passed = 0;
  int rx, ry, rw, rh;

  int          m_x [2], m_y [2], m_cnt [2], m_kcnt [2];
  bit          m_lock [2], m_ovf [2];
  logic [17:0] m_q [2][32];
  logic [15:0] klog [$];
  bit          popped [2];
  logic [17:0] pdat [2];

  cam_crop_fifo #(.XW(10), .YW(9), .CROP_X0(1), .CROP_Y0(1), .CROP_W(2), .CROP_H(2),
                  .FIFO_AW(4)) dut_a (
    .pclk_i(clk), .rst_i(rst_s), .pixel_valid_i(pv_s), .pixel_i(pix_s),
    .vstart_i(vs_s), .hstart_i(hs_s), .out_valid_o(a_valid), .out_ready_i(rdy_s),
    .out_data_o(a_data), .out_sof_o(a_sof), .out_eol_o(a_eol),
    .fifo_level_o(a_level), .overflow_o(a_ovf));

  cam_crop_fifo #(.XW(4), .YW(4), .CROP_X0(2), .CROP_Y0(3), .CROP_W(4), .CROP_H(4),
                  .FIFO_AW(4)) dut_b (
    .pclk_i(clk), .rst_i(rst_s), .pixel_valid_i(pv_s), .pixel_i(pix_s),
    .vstart_i(vs_s), .hstart_i(hs_s), .out_valid_o(b_valid), .out_ready_i(rdy_s),
    .out_data_o(b_data), .out_sof_o(b_sof), .out_eol_o(b_eol),
    .fifo_level_o(b_level), .overflow_o(b_ovf));

  function automatic int p_x0(int i);   return (i == 0) ? 1 : 2;      endfunction
  function automatic int p_y0(int i);   return (i == 0) ? 1 : 3;      endfunction
  function automatic int p_w(int i);    return (i == 0) ? 2 : 4;      endfunction
  function automatic int p_h(int i);    return (i == 0) ? 2 : 4;      endfunction
  function automatic int p_xmax(int i); return (i == 0) ? 1023 : 15;  endfunction
  function automatic int p_ymax(int i); return (i == 0) ? 511 : 15;   endfunction

  function automatic bit in_keep(int i, int x, int y);
    int dx, dy;
    bit k;
    dx = x - p_x0(i);
    dy = y - p_y0(i);
    k  = (dx >= 0) && (dx < p_w(i)) && (dy >= 0) && (dy < p_h(i));
`ifdef CAM_CROP_DECIM_EN
    k  = k && (dx % 2 == 0) && (dy % 2 == 0);
`endif
    return k;
  endfunction

  function automatic bit is_eol(int i, int x);
`ifdef CAM_CROP_DECIM_EN
    return (x - p_x0(i)) == (p_w(i) - 2);
`else
    return (x - p_x0(i)) == (p_w(i) - 1);
`endif
  endfunction

  // One clock of reference behaviour for instance i using the currently driven inputs.
  task automatic model_update(input int i);
    bit do_pop, do_keep;
    logic [17:0] ent;
    if (rst_s) begin
      m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_lock[i] = 0;
    end else begin
      do_pop  = (m_cnt[i] > 0) && rdy_s;
      do_keep = 0;
      ent     = '0;
      if (pv_s && (m_lock[i] || vs_s)) begin
        m_lock[i] = 1;
        if (vs_s) begin
          m_x[i] = 0; m_y[i] = 0;
        end else if (hs_s) begin
          m_x[i] = 0;
          if (m_y[i] < p_ymax(i)) m_y[i]++;
        end else if (m_x[i] < p_xmax(i)) begin
          m_x[i]++;
        end
        do_keep = in_keep(i, m_x[i], m_y[i]);
        ent = {(m_x[i] == p_x0(i)) && (m_y[i] == p_y0(i)), is_eol(i, m_x[i]), pix_s};
      end
      if (do_pop) begin
        for (int k = 0; k < 31; k++) m_q[i][k] = m_q[i][k+1];
        m_cnt[i]--;
      end
      if (do_keep) begin
        m_kcnt[i]++;
        if (i == 1) klog.push_back(pix_s);
        if (m_cnt[i] < 16) begin
          m_q[i][m_cnt[i]] = ent;
          m_cnt[i]++;
        end else begin
          m_ovf[i] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit vsi, input bit hsi, input bit rd,
                       input logic [15:0] p);
    @(negedge clk);
    rst_s = r; pv_s = v; vs_s = vsi; hs_s = hsi; rdy_s = rd; pix_s = p;
    popped[0] = a_valid && rd;
    pdat[0]   = {a_sof, a_eol, a_data};
    popped[1] = b_valid && rd;
    pdat[1]   = {b_sof, b_eol, b_data};
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic raster(input bit rd, input logic [15:0] p);
    step(1'b0, 1'b1, (rx == 0) && (ry == 0), rx == 0, rd, p);
    rx++;
    if (rx >= rw) begin
      rx = 0;
      ry++;
      if (ry >= rh) ry = 0;
    end
  endtask

  function automatic logic [24:0] obs(int i);
    if (i == 0) return {a_valid, a_level, a_ovf, a_valid ? {a_sof, a_eol, a_data} : 18'h0};
    return {b_valid, b_level, b_ovf, b_valid ? {b_sof, b_eol, b_data} : 18'h0};
  endfunction

  function automatic logic [24:0] expv(int i);
    logic v;
    v = m_cnt[i] > 0;
    return {v, 5'(m_cnt[i]), m_ovf[i], v ? m_q[i][0] : 18'h0};
  endfunction

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 1, 1, 1, 1, 16'hffff);
    checks++;
    if ({a_valid, a_level, a_ovf, a_sof, a_eol, a_data} !== 25'h0)
      $display("FAIL reset_a outputs got %h want 0", {a_valid, a_level, a_ovf, a_sof, a_eol, a_data});
    else passed++;
    checks++;
    if ({b_valid, b_level, b_ovf, b_sof, b_eol, b_data} !== 25'h0)
      $display("FAIL reset_b outputs got %h want 0", {b_valid, b_level, b_ovf, b_sof, b_eol, b_data});
    else passed++;
  endtask

  task automatic test_prelock;
    for (int c = 0; c < 12; c++) begin
      step(0, 1, 0, 1'($urandom_range(0, 1)), 1, 16'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL prelock dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
    checks++;
    if ({a_level, b_level} !== 10'h0) $display("FAIL prelock_level got %h want 0", {a_level, b_level});
    else passed++;
  endtask

  task automatic test_small_frame;
    int na, nsof, neol;
    bit first_sof, seen;
    na = 0; nsof = 0; neol = 0; first_sof = 0; seen = 0;
    rw = 4; rh = 4; rx = 0; ry = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) raster(1, 16'($urandom));
      else step(0, 0, 0, 0, 1, 16'h0);
      if (popped[0]) begin
        if (!seen) first_sof = pdat[0][17];
        seen = 1;
        na++;
        nsof += int'(pdat[0][17]);
        neol += int'(pdat[0][16]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL small_frame dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
`ifdef CAM_CROP_DECIM_EN
    checks++;
    if (na != 1 || neol != 1) $display("FAIL small_count got %0d/%0d want 1/1", na, neol); else passed++;
`else
    checks++;
    if (na != 4 || neol != 2) $display("FAIL small_count got %0d/%0d want 4/2", na, neol); else passed++;
`endif
    checks++;
    if (nsof != 1 || !first_sof) $display("FAIL small_sof got %0d first %0d want 1 1", nsof, first_sof);
    else passed++;
  endtask

  task automatic test_window_b;
    int nb, neol, nsof;
    nb = 0; neol = 0; nsof = 0;
    step(1, 0, 0, 0, 0, 16'h0);
    rw = 8; rh = 8; rx = 0; ry = 0;
    for (int c = 0; c < 68; c++) begin
      if (c < 64) raster(1, 16'($urandom));
      else step(0, 0, 0, 0, 1, 16'h0);
      if (popped[1]) begin
        nb++;
        neol += int'(pdat[1][16]);
        nsof += int'(pdat[1][17]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL window_b dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
`ifdef CAM_CROP_DECIM_EN
    checks++;
    if (nb != 4 || neol != 2 || nsof != 1) $display("FAIL window_b_count got %0d/%0d/%0d want 4/2/1", nb, neol, nsof);
    else passed++;
`else
    checks++;
    if (nb != 16 || neol != 4 || nsof != 1) $display("FAIL window_b_count got %0d/%0d/%0d want 16/4/1", nb, neol, nsof);
    else passed++;
`endif
  endtask

  task automatic test_overflow;
    logic [15:0] got [$];
    step(1, 0, 0, 0, 0, 16'h0);
    klog.delete();
    m_kcnt[1] = 0;
    rw = 8; rh = 8; rx = 0; ry = 0;
    for (int g = 0; g < 1000 && m_kcnt[1] < 20; g++) begin
      raster(0, 16'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL overflow_fill dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
    checks++;
    if (b_level !== 5'd16 || b_ovf !== 1'b1) $display("FAIL overflow_full got lvl %0d ovf %0d want 16 1", b_level, b_ovf);
    else passed++;
    for (int c = 0; c < 18; c++) begin
      step(0, 0, 0, 0, 1, 16'h0);
      if (popped[1]) got.push_back(pdat[1][15:0]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL overflow_drain dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
    checks++;
    if (got.size() != 16 || b_ovf !== 1'b1) $display("FAIL overflow_drain_count got %0d ovf %0d want 16 1", got.size(), b_ovf);
    else passed++;
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== klog[k]) $display("FAIL overflow_order idx %0d got %h want %h", k, got[k], klog[k]);
      else passed++;
    end
  endtask

  task automatic test_full_pushpop;
    logic [15:0] pushed, last;
    int n;
    step(1, 0, 0, 0, 0, 16'h0);
    rw = 8; rh = 8; rx = 0; ry = 0;
    for (int g = 0; g < 500 && m_cnt[1] < 16; g++) raster(0, 16'($urandom));
    for (int g = 0; g < 100 && !in_keep(1, rx, ry); g++) raster(0, 16'($urandom));
    checks++;
    if (b_level !== 5'd16) $display("FAIL pushpop_prefill got %0d want 16", b_level); else passed++;
    pushed = 16'($urandom);
    raster(1, pushed);
    checks++;
    if (b_level !== 5'd16 || b_ovf !== 1'b0) $display("FAIL pushpop_level got lvl %0d ovf %0d want 16 0", b_level, b_ovf);
    else passed++;
    n = 0; last = 16'h0;
    for (int c = 0; c < 18; c++) begin
      step(0, 0, 0, 0, 1, 16'h0);
      if (popped[1]) begin n++; last = pdat[1][15:0]; end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL pushpop_drain dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
    checks++;
    if (n != 16 || last !== pushed) $display("FAIL pushpop_last got %0d/%h want 16/%h", n, last, pushed);
    else passed++;
  endtask

  task automatic test_vh_mid;
    bit seen, sof;
    seen = 0; sof = 0;
    step(1, 0, 0, 0, 0, 16'h0);
    rw = 8; rh = 10; rx = 0; ry = 0;
    for (int g = 0; g < 200 && !(rx == 5 && ry == 7); g++) raster(1, 16'($urandom));
    step(0, 1, 1, 1, 1, 16'($urandom));
    rx = 1; ry = 0;
    for (int c = 0; c < 22; c++) begin
      if (c < 19) raster(1, 16'($urandom));
      else step(0, 0, 0, 0, 1, 16'h0);
      if (popped[0] && !seen) begin seen = 1; sof = pdat[0][17]; end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL vh_mid dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
    checks++;
    if (!seen || !sof) $display("FAIL vh_mid_sof got seen %0d sof %0d want 1 1", seen, sof); else passed++;
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0, 0, 16'h0);
    rw = 8; rh = 8; rx = 0; ry = 0;
    for (int g = 0; g < 200 && m_cnt[1] < 3; g++) raster(0, 16'($urandom));
    checks++;
    if (b_level !== 5'd3) $display("FAIL rstmid_pre got %0d want 3", b_level); else passed++;
    step(1, 1, 0, 0, 0, 16'($urandom));
    checks++;
    if (b_valid !== 1'b0 || b_level !== 5'd0) $display("FAIL rstmid_post got v %0d lvl %0d want 0 0", b_valid, b_level);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 0, 1'(c % 3 == 0), 1, 16'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL rstmid_unlocked dut%0d got %h want %h", i, obs(i), expv(i));
        else passed++;
      end
    end
  endtask

  task automatic test_random;
    int r;
    bit rd;
    step(1, 0, 0, 0, 0, 16'h0);
    rw = 8; rh = 8; rx = 0; ry = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 999));
      rd = ($urandom_range(0, 9) < 7);
      if (r == 0) begin
        step(1, 0, 0, 0, 0, 16'h0);
      end else if (r < 6) begin
        step(0, 1, 1, 1'($urandom_range(0, 1)), rd, 16'($urandom));
        rx = 1; ry = 0;
      end else if (r < 300) begin
        step(0, 0, 0, 0, rd, 16'($urandom));
      end else begin
        if (rx == 0 && ry == 0) begin
          rw = int'($urandom_range(1, 24));
          rh = int'($urandom_range(1, 22));
        end
        raster(rd, 16'($urandom));
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL random c%0d dut%0d got %h want %h", c, i, obs(i), expv(i));
        else passed++;
      end
    end
  endtask

  initial begin
    rst_s = 1'b1; pv_s = 1'b0; vs_s = 1'b0; hs_s = 1'b0; rdy_s = 1'b0; pix_s = 16'h0;
    test_reset;
    test_prelock;
    test_small_frame;
    test_window_b;
    test_overflow;
    test_full_pushpop;
    test_vh_mid;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
